// File: rtl/clk_gate_ctrl.sv
// Clock-gating controller: one idle-detect / gate / wake FSM per domain,
// with a round-robin wake arbiter that lets at most one domain ungate per
// cycle to spread inrush current.
module clk_gate_ctrl #(
  parameter int NUM_DOMAINS = 4,
  parameter int CNT_W       = 8,
  parameter int WAKE_CYCLES = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   en_i,
  input  logic                   test_en_i,
  input  logic [CNT_W-1:0]       idle_thresh_i,
  input  logic [NUM_DOMAINS-1:0] busy_i,
  input  logic [NUM_DOMAINS-1:0] wake_req_i,
  output logic [NUM_DOMAINS-1:0] clk_en_o,
  output logic [NUM_DOMAINS-1:0] ready_o,
  output logic [NUM_DOMAINS-1:0] gated_o
);

  localparam int PTR_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
  localparam logic [3:0]       WAKE_LAST = 4'(WAKE_CYCLES - 1);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(NUM_DOMAINS - 1);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_IDLE_CNT,
    ST_GATED,
    ST_WAKE
  } state_t;

  state_t                 state_q    [NUM_DOMAINS];
  logic [CNT_W-1:0]       idle_cnt_q [NUM_DOMAINS];
  logic [3:0]             wake_cnt_q [NUM_DOMAINS];
  logic [NUM_DOMAINS-1:0] clk_en_q;
  logic [NUM_DOMAINS-1:0] ready_q;
  logic [NUM_DOMAINS-1:0] gated_q;
  logic [PTR_W-1:0]       ptr_q;

  logic [NUM_DOMAINS-1:0] activity;
  logic [NUM_DOMAINS-1:0] wake_pend;
  logic [NUM_DOMAINS-1:0] grant;
  logic                   grant_valid;
  logic [PTR_W-1:0]       grant_idx;

  // Any reason for a domain to be clocked: local work, a requester, or
  // auto-gating switched off globally.
  assign activity = busy_i | wake_req_i | {NUM_DOMAINS{~en_i}};

  // Gated domains that want their clock back.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    wake_pend = '0;
    for (int d = 0; d < NUM_DOMAINS; d++) begin
      wake_pend[d] = (state_q[d] == ST_GATED) && activity[d];
    end
  end

  // Round-robin pick: first pending domain at or after the pointer.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < NUM_DOMAINS; i++) begin
      if (!grant_valid && wake_pend[(int'(ptr_q) + i) % NUM_DOMAINS]) begin
        grant_valid = 1'b1;
        grant_idx   = PTR_W'((int'(ptr_q) + i) % NUM_DOMAINS);
      end
    end
    if (grant_valid) begin
      grant[grant_idx] = 1'b1;
    end
  end

  // Arbiter pointer advances to one past the domain just granted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else if (grant_valid) begin
      ptr_q <= (grant_idx == PTR_LAST) ? '0 : grant_idx + 1'b1;
    end
  end

  // Per-domain FSM with registered clk_en / ready / gated outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: these per-domain arrays are plain flops, so every element is reset; a true RAM would not be.
      for (int d = 0; d < NUM_DOMAINS; d++) begin
        state_q[d]    <= ST_RUN;
        idle_cnt_q[d] <= '0;
        wake_cnt_q[d] <= '0;
      end
      clk_en_q <= '1;
      ready_q  <= '1;
      gated_q  <= '0;
    end else begin
      for (int d = 0; d < NUM_DOMAINS; d++) begin
        // NOTE: sequential state uses non-blocking assignments so every domain sees pre-edge values.
        unique case (state_q[d])
          ST_RUN: begin
            if (!activity[d]) begin
              state_q[d]    <= ST_IDLE_CNT;
              idle_cnt_q[d] <= '0;
            end
          end
          ST_IDLE_CNT: begin
            if (activity[d]) begin
              state_q[d]    <= ST_RUN;
              idle_cnt_q[d] <= '0;
            end else if (idle_cnt_q[d] >= idle_thresh_i) begin
              state_q[d]  <= ST_GATED;
              clk_en_q[d] <= 1'b0;
              ready_q[d]  <= 1'b0;
              gated_q[d]  <= 1'b1;
            end else if (idle_cnt_q[d] != '1) begin
              idle_cnt_q[d] <= idle_cnt_q[d] + 1'b1;
            end
          end
          ST_GATED: begin
            if (grant[d]) begin
              state_q[d]    <= ST_WAKE;
              wake_cnt_q[d] <= '0;
              clk_en_q[d]   <= 1'b1;
              gated_q[d]    <= 1'b0;
            end
          end
          ST_WAKE: begin
            // Wake cannot be aborted: inputs are deliberately ignored here.
            if (wake_cnt_q[d] == WAKE_LAST) begin
              state_q[d] <= ST_RUN;
              ready_q[d] <= 1'b1;
            end else begin
              wake_cnt_q[d] <= wake_cnt_q[d] + 1'b1;
            end
          end
          default: state_q[d] <= ST_RUN;
        endcase
      end
    end
  end

  // Test override only touches the ICG enable, never FSM state or status.
  assign clk_en_o = clk_en_q | {NUM_DOMAINS{test_en_i}};
  assign ready_o  = ready_q;
  assign gated_o  = gated_q;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Self-checking bench for clk_gate_ctrl: directed scenarios plus a random
// phase, all compared against a behavioural per-domain model.
module tb_clk_gate_ctrl;

  localparam int N     = 4;
  localparam int CW    = 8;
  localparam int WC    = 2;
  localparam int CMAX  = (1 << CW) - 1;
  localparam int P_ACT = 0;
  localparam int P_GAT = 1;
  localparam int P_WAK = 2;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          en_i;
  logic          test_en_i;
  logic [CW-1:0] idle_thresh_i;
  logic [N-1:0]  busy_i;
  logic [N-1:0]  wake_req_i;
  logic [N-1:0]  clk_en_o;
  logic [N-1:0]  ready_o;
  logic [N-1:0]  gated_o;

  int errors = 0;
  int checks = 0;

  // Model: a domain is active (idle_len < 0 means not yet counting idle),
  // gated, or waking with wake_left edges to go.
  int phase     [N];
  int idle_len  [N];
  int wake_left [N];
  int rr_ptr;

  clk_gate_ctrl #(.NUM_DOMAINS(N), .CNT_W(CW), .WAKE_CYCLES(WC)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .test_en_i(test_en_i),
    .idle_thresh_i(idle_thresh_i), .busy_i(busy_i), .wake_req_i(wake_req_i),
    .clk_en_o(clk_en_o), .ready_o(ready_o), .gated_o(gated_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
      $error("check %s", tag);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < N; d++) begin
      phase[d] = P_ACT; idle_len[d] = -1; wake_left[d] = 0;
    end
    rr_ptr = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    logic [N-1:0] req;
    int sat;
    bit wants;
    req = '0;
    for (int d = 0; d < N; d++) begin
      wants = busy_i[d] || wake_req_i[d] || !en_i;
      if (phase[d] == P_ACT) begin
        if (idle_len[d] < 0) begin
          if (!wants) idle_len[d] = 0;
        end else if (wants) begin
          idle_len[d] = -1;
        end else begin
          sat = (idle_len[d] > CMAX) ? CMAX : idle_len[d];
          if (sat >= int'(idle_thresh_i)) phase[d] = P_GAT;
          else idle_len[d]++;
        end
      end else if (phase[d] == P_WAK) begin
        wake_left[d]--;
        if (wake_left[d] == 0) begin
          phase[d] = P_ACT; idle_len[d] = -1;
        end
      end else if (wants) begin
        req[d] = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      int d;
      d = (rr_ptr + i) % N;
      if (req[d]) begin
        phase[d] = P_WAK; wake_left[d] = WC; rr_ptr = (d + 1) % N;
        break;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    logic [N-1:0] e_en, e_rdy, e_gat;
    for (int d = 0; d < N; d++) begin
      e_en[d]  = (phase[d] != P_GAT) || test_en_i;
      e_rdy[d] = (phase[d] == P_ACT);
      e_gat[d] = (phase[d] == P_GAT);
    end
    check({tag, ".clk_en"}, clk_en_o, e_en);
    check({tag, ".ready"},  ready_o,  e_rdy);
    check({tag, ".gated"},  gated_o,  e_gat);
  endtask

  task automatic step(input string tag);
    @(posedge clk_i);
    model_edge();
    #1;
    compare_all(tag);
  endtask

  task automatic steps(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  // Apply reset away from a clock edge and release it before the next edge.
  task automatic do_reset();
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    model_reset();
    check("rst.clk_en", clk_en_o, '1);
    check("rst.ready",  ready_o,  '1);
    check("rst.gated",  gated_o,  '0);
    #1;
    rst_ni = 1'b1;
  endtask

  initial begin
    rst_ni = 1'b1; en_i = 1'b0; test_en_i = 1'b0; idle_thresh_i = '0;
    busy_i = '0; wake_req_i = '0;
    model_reset();
    #2;
    do_reset();

    // First edge after release keeps reset outputs even though gating is allowed.
    en_i = 1'b1; idle_thresh_i = 8'd3; busy_i = 4'b1110;
    step("hold");
    check("hold.clk_en", clk_en_o, 4'hF);
    check("hold.ready",  ready_o,  4'hF);

    // Gating: idle from edge 0, gated after edge 4.
    steps("gate", 3);
    check("gate.pre", gated_o, 4'b0000);
    step("gate");
    check("gate.gated",  gated_o,  4'b0001);
    check("gate.clk_en", clk_en_o, 4'b1110);

    // Abort: busy pulsed at edge 2 of the idle count keeps the clock on.
    do_reset();
    en_i = 1'b1; idle_thresh_i = 8'd3; busy_i = 4'b1110;
    steps("abort", 2);
    busy_i[0] = 1'b1;
    step("abort");
    busy_i[0] = 1'b0;
    steps("abort", 3);
    check("abort.clk_en", clk_en_o, 4'hF);
    steps("abort", 2);
    check("abort.regate", gated_o, 4'b0001);

    // Wake latency on domain 1, then arbitration starting from pointer 2.
    do_reset();
    en_i = 1'b1; idle_thresh_i = 8'd0; busy_i = '0;
    steps("gall", 2);
    check("gall.gated", gated_o, 4'hF);
    wake_req_i = 4'b0010;
    step("wake");
    wake_req_i = '0;
    check("wake.clk_en", clk_en_o, 4'b0010);
    check("wake.ready0", ready_o, 4'b0000);
    step("wake");
    check("wake.ready1", ready_o, 4'b0000);
    step("wake");
    check("wake.ready2", ready_o, 4'b0010);
    steps("regate", 3);
    check("regate.gated", gated_o, 4'hF);
    wake_req_i = 4'hF;
    step("arb");
    check("arb.g2", clk_en_o, 4'b0100);
    step("arb");
    check("arb.g3", clk_en_o, 4'b1100);
    step("arb");
    check("arb.g0", clk_en_o, 4'b1101);
    step("arb");
    check("arb.g1", clk_en_o, 4'b1111);
    wake_req_i = '0;
    steps("arb", 6);
    check("arb.regated", gated_o, 4'hF);

    // Override: test_en forces enables without touching status.
    test_en_i = 1'b1;
    #1;
    check("ovr.clk_en", clk_en_o, 4'hF);
    check("ovr.gated",  gated_o,  4'hF);
    check("ovr.ready",  ready_o,  4'h0);
    test_en_i = 1'b0;
    en_i = 1'b0;
    steps("ovr_wake", 2);

    // Reset in the middle of a wake.
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    model_reset();
    check("rstwake.clk_en", clk_en_o, 4'hF);
    check("rstwake.ready",  ready_o,  4'hF);
    check("rstwake.gated",  gated_o,  4'h0);
    rst_ni = 1'b1;

    // Saturation boundary: maximum threshold on domain 0.
    en_i = 1'b1; idle_thresh_i = 8'hFF; busy_i = 4'b1110;
    steps("sat", 258);
    check("sat.gated", gated_o, 4'b0001);

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      for (int d = 0; d < N; d++) begin
        busy_i[d]     = ($urandom_range(0, 7) == 0);
        wake_req_i[d] = ($urandom_range(0, 15) == 0);
      end
      en_i          = ($urandom_range(0, 15) != 0);
      test_en_i     = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 7) == 0) idle_thresh_i = CW'($urandom_range(0, 6));
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
